// File: rtl/and_gate_checker.sv
// and_gate_checker: scores an external AND gate against the AND-reduction of
// its stimulus pattern, tracks pattern coverage and reports pass/fail,
// a saturating mismatch count, the first failing pattern and a timeout.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no run active, waiting for start
// CHECK | run active, scoring every vld sample (busy=1)
// DONE  | run finished by full coverage or timeout, results held (done=1)

module and_gate_checker #(
    parameter int N     = 3,
    parameter int ERR_W = 8,
    parameter int TMO   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  vld,
    input  logic [N-1:0]          pat,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [ERR_W-1:0]      err_cnt,
    output logic [(1<<N)-1:0]     cov_map,
    output logic [N-1:0]          first_err_pat,
    output logic                  first_err_vld
);

    localparam int COV_W = 1 << N;
    localparam int IW    = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idle_rem;

    logic             mismatch;
    logic [COV_W-1:0] sample_bit;
    logic [COV_W-1:0] cov_next;
    logic             cov_full;
    logic [ERR_W-1:0] err_inc;
    logic             idle_tc;

    // Per-sample scoring: expected response, coverage update and saturating count.
    always_comb begin
        sample_bit      = '0;
        sample_bit[pat] = 1'b1;
        cov_next        = cov_map | sample_bit;
        cov_full        = &cov_next;
        mismatch        = (&pat) != dut_out;
        err_inc         = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);
        idle_tc         = (idle_rem == IW'(1));
    end

    // Run controller; every output is a register updated here.
    // The idle timer is a down-counter reloaded with TMO, expiring at terminal count 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            cov_map       <= '0;
            first_err_pat <= '0;
            first_err_vld <= 1'b0;
            idle_rem      <= IW'(TMO);
        end else if (start) begin
            // Start from any state begins a fresh run; this cycle's sample is dropped.
            state         <= CHECK;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            cov_map       <= '0;
            first_err_pat <= '0;
            first_err_vld <= 1'b0;
            idle_rem      <= IW'(TMO);
        end else begin
            case (state)
                CHECK: begin
                    if (vld) begin
                        if (mismatch) begin
                            err_cnt <= err_inc;
                            if (!first_err_vld) begin
                                first_err_pat <= pat;
                                first_err_vld <= 1'b1;
                            end
                        end
                        cov_map  <= cov_next;
                        idle_rem <= IW'(TMO);
                        // Coverage can only complete on a vld cycle and the timer only
                        // expires on a non-vld cycle, so coverage always wins a tie.
                        if (cov_full) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_cnt == '0) && !mismatch;
                            timeout <= 1'b0;
                        end
                    end else if (idle_tc) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        idle_rem <= idle_rem - IW'(1);
                    end
                end
                IDLE, DONE: begin
                    state <= state;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and_gate_checker.sv
// tb_and_gate_checker: drives two checker instances (default widths and a
// 2-bit error counter) with shared stimulus; a behavioural model pushes the
// expected outputs for each cycle and they are popped after the edge.

module tb_and_gate_checker;

    localparam int N   = 3;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst, start, vld, dut_out;
    logic [N-1:0] pat;

    logic       busy, done, pass, timeout, fev;
    logic [7:0] err_cnt, cov_map;
    logic [2:0] fep;

    logic       s_busy, s_done, s_pass, s_timeout, s_fev;
    logic [1:0] s_err_cnt;
    logic [7:0] s_cov_map;
    logic [2:0] s_fep;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct packed {
        logic       busy, done, pass, tmo;
        logic [7:0] err;
        logic [1:0] err2;
        logic [7:0] cov;
        logic [2:0] fep;
        logic       fev;
    } exp_t;

    exp_t exp_q[$];

    // model state
    int         m_state, m_err, m_idle;
    logic       m_busy, m_done, m_pass, m_tmo, m_fev;
    logic [7:0] m_cov;
    logic [2:0] m_fep;

    and_gate_checker #(.N(N), .ERR_W(8), .TMO(TMO)) u_dut (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .pat(pat), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt),
        .cov_map(cov_map), .first_err_pat(fep), .first_err_vld(fev)
    );

    and_gate_checker #(.N(N), .ERR_W(2), .TMO(TMO)) u_sat (
        .clk(clk), .rst(rst), .start(start), .vld(vld), .pat(pat), .dut_out(dut_out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout), .err_cnt(s_err_cnt),
        .cov_map(s_cov_map), .first_err_pat(s_fep), .first_err_vld(s_fev)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic v,
                              input logic [2:0] p, input logic d);
        exp_t e;
        if (r) begin
            m_state = 0; m_busy = 0; m_done = 0; m_pass = 0; m_tmo = 0;
            m_err = 0; m_cov = '0; m_fep = '0; m_fev = 0; m_idle = 0;
        end else if (s) begin
            m_state = 1; m_busy = 1; m_done = 0; m_pass = 0; m_tmo = 0;
            m_err = 0; m_cov = '0; m_fep = '0; m_fev = 0; m_idle = 0;
        end else if (m_state == 1) begin
            if (v) begin
                if ((&p) !== d) begin
                    m_err++;
                    if (!m_fev) begin
                        m_fev = 1;
                        m_fep = p;
                    end
                end
                m_cov[p] = 1'b1;
                m_idle   = 0;
                if (m_cov == 8'hFF) begin
                    m_state = 2; m_busy = 0; m_done = 1; m_pass = (m_err == 0); m_tmo = 0;
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_state = 2; m_busy = 0; m_done = 1; m_pass = 0; m_tmo = 1;
                end
            end
        end
        e.busy = m_busy; e.done = m_done; e.pass = m_pass; e.tmo = m_tmo;
        e.err  = (m_err > 255) ? 8'hFF : 8'(m_err);
        e.err2 = (m_err > 3) ? 2'd3 : 2'(m_err);
        e.cov  = m_cov; e.fep = m_fep; e.fev = m_fev;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic v,
                       input logic [2:0] p, input logic d);
        exp_t e;
        rst = r; start = s; vld = v; pat = p; dut_out = d;
        model_step(r, s, v, p, d);
        @(posedge clk);
        #1;
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
            chk("pass", pass, e.pass);
            chk("timeout", timeout, e.tmo);
            chk("err_cnt", err_cnt, e.err);
            chk("cov_map", cov_map, e.cov);
            chk("first_err_pat", fep, e.fep);
            chk("first_err_vld", fev, e.fev);
            chk("sat_err_cnt", s_err_cnt, e.err2);
            chk("sat_done", s_done, e.done);
            chk("sat_pass", s_pass, e.pass);
            chk("sat_cov_map", s_cov_map, e.cov);
        end
    endtask

    task automatic sweep(input int lo, input int hi, input bit stuck0);
        logic [2:0] p;
        for (int k = lo; k <= hi; k++) begin
            p = 3'(k);
            cyc(0, 0, 1, p, stuck0 ? 1'b0 : &p);
        end
    endtask

    initial begin
        logic [2:0] rp;
        logic       rv, rd, rs;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 7, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cov", cov_map, 0);

        // correct gate, full sweep
        cyc(0, 1, 0, 0, 0);
        chk("start_busy", busy, 1);
        sweep(0, 6, 0);
        chk("r35_not_done", done, 0);
        sweep(7, 7, 0);
        chk("r35_done", done, 1);
        chk("r35_pass", pass, 1);
        chk("r35_err", err_cnt, 0);
        chk("r35_cov", cov_map, 8'hFF);

        // stuck-at-0 gate
        cyc(0, 1, 0, 0, 0);
        sweep(0, 7, 1);
        chk("r36_done", done, 1);
        chk("r36_pass", pass, 0);
        chk("r36_err", err_cnt, 1);
        chk("r36_fep", fep, 3'b111);

        // DONE ignores vld
        cyc(0, 0, 1, 3, 1);
        cyc(0, 0, 1, 0, 1);
        chk("done_hold_err", err_cnt, 1);

        // timeout
        cyc(0, 1, 0, 0, 0);
        sweep(0, 3, 0);
        repeat (TMO - 1) cyc(0, 0, 0, 0, 0);
        chk("r37_not_yet", done, 0);
        cyc(0, 0, 0, 0, 0);
        chk("r37_done", done, 1);
        chk("r37_timeout", timeout, 1);
        chk("r37_pass", pass, 0);
        chk("r37_cov", cov_map, 8'h0F);

        // repeats and saturation; vld during start is dropped
        cyc(0, 1, 1, 7, 0);
        chk("r38_start_drop", err_cnt, 0);
        repeat (5) cyc(0, 0, 1, 7, 0);
        sweep(0, 6, 0);
        chk("r38_sat_err", s_err_cnt, 2'd3);
        chk("r38_err", err_cnt, 5);
        chk("r38_fep", fep, 3'd7);
        chk("r38_pass", pass, 0);
        chk("r38_done", done, 1);

        // random run scored by the model
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            rp = 3'($urandom_range(0, 7));
            rv = ($urandom_range(0, 3) != 0);
            rd = (&rp) ^ ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 39) == 0);
            cyc(0, rs, rv, rp, rd);
        end

        // restart mid-run, then reset mid-run
        cyc(0, 1, 0, 0, 0);
        sweep(0, 1, 0);
        cyc(0, 0, 1, 2, 1);
        sweep(3, 4, 0);
        chk("r39_pre_fev", fev, 1);
        cyc(0, 1, 1, 5, 1);
        chk("r39_restart_cov", cov_map, 0);
        chk("r39_restart_err", err_cnt, 0);
        chk("r39_restart_busy", busy, 1);
        chk("r39_restart_fev", fev, 0);
        cyc(0, 0, 1, 7, 0);
        cyc(0, 0, 1, 6, 1);
        cyc(1, 1, 1, 3, 1);
        chk("r39_rst_busy", busy, 0);
        chk("r39_rst_err", err_cnt, 0);
        chk("r39_rst_fep", fep, 0);
        chk("r39_rst_fev", fev, 0);
        cyc(0, 0, 1, 7, 0);
        chk("r39_idle_ignores", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
